fft_frame_pingpong_ctrl: RTL and testbench

- Scheduler for two 128-entry shift-register frame FIFOs (A, B) between the audio sample stream and the FFT input.
- Steers incoming samples into the "fill" FIFO while the other "drain" FIFO streams a complete frame to the FFT core over a valid/ready handshake.
- Swaps roles at each frame boundary and issues the FFT start pulse.
- Flags overruns and FIFO errors.

---
 rtl/fft_frame_pingpong_ctrl.sv | 101 ++++++++++
 tb/tb_fft_frame_pingpong_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_pingpong_ctrl.sv
// fft_frame_pingpong_ctrl: steers samples into one frame FIFO while the other drains to the FFT, swapping at frame boundaries.
module fft_frame_pingpong_ctrl #(
    parameter int FRAME_LEN = 128,
    parameter int CNT_W     = 8,
    parameter int DWIDTH    = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              clr_status,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic [DWIDTH-1:0] wr_data,
    output logic              wr_ce_a,
    output logic              wr_ce_b,
    output logic              rd_ce_a,
    output logic              rd_ce_b,
    output logic              start_fft_a,
    output logic              start_fft_b,
    input  logic [DWIDTH-1:0] dout_a,
    input  logic [DWIDTH-1:0] dout_b,
    input  logic              err_a,
    input  logic              err_b,
    output logic              fft_valid,
    output logic [DWIDTH-1:0] fft_data,
    output logic              fft_last,
    input  logic              fft_ready,
    output logic              start_fft,
    output logic              fill_sel,
    output logic              busy,
    output logic              overrun,
    output logic              fifo_err,
    output logic [15:0]       drop_cnt
);
    typedef enum logic [1:0] {IDLE, START, DRAIN} state_t;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    state_t           state;
    logic             drain_sel;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             idle, pending, in_ok, accept, swap_b, swap, late_wr, drop, xfer;
    assign idle    = state == IDLE;
    assign pending = wr_cnt == FULL;
    assign in_ok   = s_valid & enable;
    assign accept  = in_ok & (wr_cnt < FULL);
    assign swap_b  = pending & idle;
    assign swap    = (accept & (wr_cnt == LAST) & idle) | swap_b;
    // a sample arriving on a deferred swap goes straight into the newly freed FIFO
    assign late_wr = in_ok & swap_b;
    assign drop    = in_ok & pending & ~swap_b;
    assign xfer    = (state == DRAIN) & fft_ready;
    assign wr_data     = s_data;
    assign wr_ce_a     = (accept & ~fill_sel) | (late_wr & fill_sel);
    assign wr_ce_b     = (accept & fill_sel) | (late_wr & ~fill_sel);
    assign rd_ce_a     = xfer & ~drain_sel;
    assign rd_ce_b     = xfer & drain_sel;
    assign start_fft   = state == START;
    assign start_fft_a = start_fft & ~drain_sel;
    assign start_fft_b = start_fft & drain_sel;
    assign fft_valid   = state == DRAIN;
    assign fft_data    = drain_sel ? dout_b : dout_a;
    assign fft_last    = fft_valid & (rd_cnt == LAST);
    assign busy        = ~idle;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            drain_sel <= 1'b0;
            fill_sel  <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            overrun   <= 1'b0;
            fifo_err  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (swap) begin
                fill_sel  <= ~fill_sel;
                drain_sel <= fill_sel;
                wr_cnt    <= late_wr ? CNT_W'(1) : '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            case (state)
                IDLE:    if (swap) state <= START;
                START: begin
                    rd_cnt <= '0;
                    state  <= DRAIN;
                end
                DRAIN: if (xfer) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (fft_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a drop or error coincident with clr_status survives the clear
            overrun  <= drop | (overrun & ~clr_status);
            fifo_err <= err_a | err_b | (fifo_err & ~clr_status);
            drop_cnt <= clr_status ? {15'b0, drop} : drop_cnt + {15'b0, drop & ~&drop_cnt};
        end
    end
endmodule

// File: tb/tb_fft_frame_pingpong_ctrl.sv
// tb_fft_frame_pingpong_ctrl: directed bench with behavioural frame FIFOs and an output scoreboard.
module tb_fft_frame_pingpong_ctrl;
    logic        clk = 1'b0;
    logic        n_rst, enable, clr_status, s_valid, fft_ready, err_a, err_b;
    logic [31:0] s_data, dout_a, dout_b, wr_data, fft_data;
    logic        wr_ce_a, wr_ce_b, rd_ce_a, rd_ce_b, start_fft_a, start_fft_b;
    logic        fft_valid, fft_last, start_fft, fill_sel, busy, overrun, fifo_err;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          errors = 0;
    int          rx_n = 0;
    int          exp_tgt = 2;
    logic [31:0] fa[$];
    logic [31:0] fb[$];
    logic [31:0] exp_q[$];

    fft_frame_pingpong_ctrl dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .clr_status(clr_status),
        .s_valid(s_valid), .s_data(s_data), .wr_data(wr_data),
        .wr_ce_a(wr_ce_a), .wr_ce_b(wr_ce_b), .rd_ce_a(rd_ce_a), .rd_ce_b(rd_ce_b),
        .start_fft_a(start_fft_a), .start_fft_b(start_fft_b),
        .dout_a(dout_a), .dout_b(dout_b), .err_a(err_a), .err_b(err_b),
        .fft_valid(fft_valid), .fft_data(fft_data), .fft_last(fft_last),
        .fft_ready(fft_ready), .start_fft(start_fft), .fill_sel(fill_sel),
        .busy(busy), .overrun(overrun), .fifo_err(fifo_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs are stable here, so the enables seen are the ones the next edge commits
    task automatic mon();
        if (!n_rst) begin
            fa.delete();
            fb.delete();
            exp_q.delete();
            rx_n = 0;
        end else begin
            chk("wr_ce", {62'b0, wr_ce_b, wr_ce_a}, exp_tgt == 0 ? 64'd1 : exp_tgt == 1 ? 64'd2 : 64'd0);
            chk("wr_rd_overlap", {63'b0, (wr_ce_a & rd_ce_a) | (wr_ce_b & rd_ce_b)}, 64'd0);
            if (fft_valid) begin
                chk("sb_avail", {63'b0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) chk("fft_data", {32'b0, fft_data}, {32'b0, exp_q[0]});
                if (fft_ready) begin
                    chk("fft_last", {63'b0, fft_last}, {63'b0, rx_n % 128 == 127});
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    rx_n++;
                end
            end
            if (wr_ce_a) fa.push_back(wr_data);
            if (wr_ce_b) fb.push_back(wr_data);
            if (rd_ce_a && fa.size() > 0) void'(fa.pop_front());
            if (rd_ce_b && fb.size() > 0) void'(fb.pop_front());
        end
        dout_a = fa.size() > 0 ? fa[0] : 32'b0;
        dout_b = fb.size() > 0 ? fb[0] : 32'b0;
    endtask

    task automatic cyc();
        #1;
        mon();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input int tgt);
        s_valid = 1'b1;
        s_data  = d;
        exp_tgt = tgt;
        if (tgt < 2) exp_q.push_back(d);
        cyc();
        s_valid = 1'b0;
        exp_tgt = 2;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            cyc();
            n++;
        end
        chk("drain_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {51'b0, wr_ce_a, wr_ce_b, rd_ce_a, rd_ce_b, start_fft_a, start_fft_b,
            fft_valid, fft_last, start_fft, fill_sel, busy, overrun, fifo_err}, 64'd0);
        chk({tag, "_drop"}, {48'b0, drop_cnt}, 64'd0);
        chk({tag, "_data"}, {wr_data, fft_data}, 64'd0);
    endtask

    task automatic do_reset();
        n_rst   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        exp_tgt = 2;
        cyc();
        cyc();
        n_rst = 1'b1;
    endtask

    initial begin
        int k;
        int base;
        n_rst = 0; enable = 1; clr_status = 0; s_valid = 0; s_data = 0;
        fft_ready = 1; err_a = 0; err_b = 0; dout_a = 0; dout_b = 0;
        cyc();
        cyc();
        chk_zero("reset");
        n_rst = 1'b1;

        // single frame into A, then drained in order
        for (int i = 0; i < 128; i++) send(32'(i), 0);
        chk("t1_start", {61'b0, start_fft, start_fft_a, start_fft_b}, 64'd6);
        chk("t1_fill_sel", {63'b0, fill_sel}, 64'd1);
        cyc();
        chk("t1_first_valid", {62'b0, fft_valid, start_fft}, 64'd2);
        wait_idle(300);
        chk("t1_rx", rx_n, 128);

        // three frames with a short gap at each boundary: A, B, A
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 128; j++) send(32'(f * 128 + j), f % 2);
            for (int j = 0; j < 3; j++) cyc();
        end
        wait_idle(300);
        chk("t2_rx", rx_n, 384);
        chk("t2_overrun", {63'b0, overrun}, 64'd0);
        chk("t2_fill_sel", {63'b0, fill_sel}, 64'd1);
        chk("t2_sb_empty", exp_q.size(), 0);

        // slow drain of A while B fills and overflows
        do_reset();
        fft_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(32'(1000 + i), 0);
        chk("t3_start_a", {62'b0, start_fft_a, start_fft_b}, 64'd2);
        for (int i = 0; i < 128; i++) begin
            fft_ready = (i % 4 == 0);
            send(32'(2000 + i), 1);
        end
        fft_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(32'(2500 + i), 2);
        chk("t3_overrun", {63'b0, overrun}, 64'd1);
        chk("t3_drop_cnt", {48'b0, drop_cnt}, 64'd10);
        clr_status = 1'b1;
        send(32'd2600, 2);
        clr_status = 1'b0;
        chk("t3_clr_drop_cnt", {48'b0, drop_cnt}, 64'd1);
        chk("t3_clr_overrun", {63'b0, overrun}, 64'd1);
        k = 0;
        while (rx_n < 127 && k < 1000) begin
            fft_ready = (k % 4 == 0);
            cyc();
            k++;
        end
        chk("t3_wait_127", rx_n, 127);
        fft_ready = 1'b1;
        cyc();
        chk("t3_idle_after_last", {62'b0, busy, start_fft}, 64'd0);
        send(32'd3000, 0);
        chk("t3_swap_b", {61'b0, start_fft, start_fft_a, start_fft_b}, 64'd5);
        chk("t3_fill_sel", {63'b0, fill_sel}, 64'd0);
        wait_idle(400);
        chk("t3_rx", rx_n, 256);

        // enable low mid-fill: samples ignored, fill resumes at the same count
        for (int i = 0; i < 60; i++) send(32'(4000 + i), 0);
        enable = 1'b0;
        for (int i = 0; i < 50; i++) send(32'(4500 + i), 2);
        enable = 1'b1;
        chk("t4_drop_cnt", {48'b0, drop_cnt}, 64'd1);
        for (int i = 60; i < 126; i++) send(32'(4000 + i), 0);
        chk("t4_not_yet", {62'b0, busy, start_fft}, 64'd0);
        send(32'd4126, 0);
        chk("t4_start", {62'b0, start_fft, fill_sel}, 64'd3);
        wait_idle(300);
        chk("t4_sb_empty", exp_q.size(), 0);

        // sticky error flag and status clear
        err_b = 1'b1;
        cyc();
        err_b = 1'b0;
        cyc();
        cyc();
        chk("t6_fifo_err", {63'b0, fifo_err}, 64'd1);
        clr_status = 1'b1;
        cyc();
        clr_status = 1'b0;
        chk("t6_clear", {46'b0, fifo_err, overrun, drop_cnt}, 64'd0);

        // reset in the middle of a drain
        base = rx_n;
        for (int i = 0; i < 128; i++) send(32'(5000 + i), 1);
        k = 0;
        while (rx_n - base < 60 && k < 300) begin
            cyc();
            k++;
        end
        chk("t5_rd60", rx_n - base, 60);
        n_rst   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        cyc();
        chk_zero("t5_rst");
        n_rst = 1'b1;
        for (int i = 0; i < 128; i++) send(32'(6000 + i), 0);
        chk("t5_start_a", {62'b0, start_fft_a, fill_sel}, 64'd3);
        wait_idle(300);
        chk("t5_rx", rx_n, 128);
        chk("t5_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
